// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: debounced button levels and counter status in,
// counter commands and status indicators out.
// The controller attaches through the slave modport. The stimulus side or
// board glue attaches through the master modport.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_load;
  logic       btn_clear;
  logic       cnt_term;
  logic       cnt_inc;
  logic       cnt_ld;
  logic       cnt_clr;
  logic [1:0] state;
  logic       running;
  logic       alarm;

  modport master (
    output btn_start, btn_stop, btn_load, btn_clear, cnt_term,
    input  cnt_inc, cnt_ld, cnt_clr, state, running, alarm
  );

  modport slave (
    input  btn_start, btn_stop, btn_load, btn_clear, cnt_term,
    output cnt_inc, cnt_ld, cnt_clr, state, running, alarm
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control FSM between the button debouncer and the display
// counter. It turns debounced button levels into one-cycle commands. It also
// owns the count-rate prescaler. It sequences the counter through
// IDLE/RUN/PAUSE/DONE.
//
// Optional feature macro: STOPWATCH_ALARM_EN
//   defined     - in DONE, alarm blinks. It starts at 1 and toggles every
//                 TICK_DIV cycles. The prescaler keeps running in DONE only
//                 to time the blink.
//   not defined - alarm is a steady copy of (state == DONE). The prescaler is
//                 frozen at 0 in DONE.
//
// All outputs are registered. A button edge sampled at clock edge k is
// visible on the outputs right after edge k.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50_000_000,  // clk cycles per count tick, >= 2
  parameter int DIV_W    = 26           // 2**DIV_W >= TICK_DIV
) (
  input  logic             clk_50MHz,
  input  logic             reset,       // async, active low
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] PRESC_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  // Button history: the level seen at the previous clock edge.
  logic start_q_r;
  logic stop_q_r;
  logic load_q_r;
  logic clear_q_r;

  // Raw rising edges, then the single surviving command after priority.
  logic start_edge_s;
  logic stop_edge_s;
  logic load_edge_s;
  logic clear_edge_s;
  logic cmd_clear_s;
  logic cmd_stop_s;
  logic cmd_load_s;
  logic cmd_start_s;

  // FSM state, prescaler and registered outputs.
  state_t           state_r;
  logic [DIV_W-1:0] presc_r;
  logic             tick_s;
  logic             inc_r;
  logic             ld_r;
  logic             clr_r;
  logic             running_r;
  logic             alarm_r;

  // A level held high yields one edge only, because the history then matches it.
  assign start_edge_s = bus.btn_start & ~start_q_r;
  assign stop_edge_s  = bus.btn_stop  & ~stop_q_r;
  assign load_edge_s  = bus.btn_load  & ~load_q_r;
  assign clear_edge_s = bus.btn_clear & ~clear_q_r;

  // The prescaler wraps on this cycle, so a count tick occurs here.
  assign tick_s = (presc_r == PRESC_LAST);

  // Capture button history. It resets to 0, so a button already held at
  // reset release still produces one edge.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      start_q_r <= 1'b0;
      stop_q_r  <= 1'b0;
      load_q_r  <= 1'b0;
      clear_q_r <= 1'b0;
    end else begin
      start_q_r <= bus.btn_start;
      stop_q_r  <= bus.btn_stop;
      load_q_r  <= bus.btn_load;
      clear_q_r <= bus.btn_clear;
    end
  end

  // Priority select: clear > stop > load > start.
  // Only the highest edge present survives. The lower edges are dropped,
  // even when the winner has no effect in the current state.
  always_comb begin
    cmd_clear_s = 1'b0;
    cmd_stop_s  = 1'b0;
    cmd_load_s  = 1'b0;
    cmd_start_s = 1'b0;
    if (clear_edge_s) begin
      cmd_clear_s = 1'b1;
    end else if (stop_edge_s) begin
      cmd_stop_s = 1'b1;
    end else if (load_edge_s) begin
      cmd_load_s = 1'b1;
    end else if (start_edge_s) begin
      cmd_start_s = 1'b1;
    end else begin
      cmd_start_s = 1'b0;
    end
  end

  // Main FSM: state, prescaler, one-cycle command pulses and status outputs.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      presc_r   <= PRESC_ZERO;
      inc_r     <= 1'b0;
      ld_r      <= 1'b0;
      clr_r     <= 1'b0;
      running_r <= 1'b0;
      alarm_r   <= 1'b0;
    end else begin
      // Pulses last one cycle unless a branch below re-asserts them.
      inc_r <= 1'b0;
      ld_r  <= 1'b0;
      clr_r <= 1'b0;

      if (cmd_clear_s) begin
        clr_r     <= 1'b1;
        state_r   <= ST_IDLE;
        presc_r   <= PRESC_ZERO;
        running_r <= 1'b0;
        alarm_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (cmd_load_s) begin
              ld_r <= 1'b1;
            end else if (cmd_start_s) begin
              state_r   <= ST_RUN;
              presc_r   <= PRESC_ZERO;
              running_r <= 1'b1;
            end else begin
              presc_r <= PRESC_ZERO;
            end
          end

          ST_RUN: begin
            if (cmd_stop_s) begin
              // Stop wins over a coincident tick. The prescaler keeps its
              // value so the resumed run neither loses nor repeats a tick.
              state_r   <= ST_PAUSE;
              running_r <= 1'b0;
            end else if (tick_s) begin
              presc_r <= PRESC_ZERO;
              if (bus.cnt_term) begin
                state_r   <= ST_DONE;
                running_r <= 1'b0;
                alarm_r   <= 1'b1;
              end else begin
                inc_r <= 1'b1;
              end
            end else begin
              presc_r <= presc_r + PRESC_ONE;
            end
          end

          ST_PAUSE: begin
            if (cmd_load_s) begin
              ld_r    <= 1'b1;
              presc_r <= PRESC_ZERO;
            end else if (cmd_start_s) begin
              state_r   <= ST_RUN;
              running_r <= 1'b1;
            end else begin
              presc_r <= presc_r;
            end
          end

          ST_DONE: begin
            if (cmd_load_s) begin
              ld_r    <= 1'b1;
              state_r <= ST_IDLE;
              presc_r <= PRESC_ZERO;
              alarm_r <= 1'b0;
            end else begin
`ifdef STOPWATCH_ALARM_EN
              // In DONE the prescaler only times the alarm blink.
              if (tick_s) begin
                presc_r <= PRESC_ZERO;
                alarm_r <= ~alarm_r;
              end else begin
                presc_r <= presc_r + PRESC_ONE;
              end
`else
              presc_r <= PRESC_ZERO;
              alarm_r <= 1'b1;
`endif
            end
          end

          default: begin
            state_r   <= ST_IDLE;
            presc_r   <= PRESC_ZERO;
            running_r <= 1'b0;
            alarm_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cnt_inc = inc_r;
  assign bus.cnt_ld  = ld_r;
  assign bus.cnt_clr = clr_r;
  assign bus.state   = state_r;
  assign bus.running = running_r;
  assign bus.alarm   = alarm_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, default build (no alarm blink).
// Observation vector: {state[1:0], running, cnt_inc, cnt_ld, cnt_clr, alarm}.
module tb_stopwatch_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(.TICK_DIV(4), .DIV_W(3)) dut (
    .clk_50MHz (clk),
    .reset     (reset),
    .bus       (bus)
  );

  logic [6:0] obs;
  assign obs = {bus.state, bus.running, bus.cnt_inc, bus.cnt_ld, bus.cnt_clr, bus.alarm};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_load = 1'b0;
    bus.btn_clear = 1'b0; bus.cnt_term = 1'b0;
    #3;
    n_cmp++;
    if (obs !== 7'b0000000) begin n_bad++; $display("FAIL reset_async: got %b want %b", obs, 7'b0000000); end
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (obs !== 7'b0000000) begin n_bad++; $display("FAIL reset_idle[%0d]: got %b want %b", i, obs, 7'b0000000); end
    end
  endtask

  task automatic test_run_ticks();
    int pulses;
    logic [6:0] exp;
    pulses = 0;
    bus.btn_start = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b0110000) begin n_bad++; $display("FAIL run_entry: got %b want %b", obs, 7'b0110000); end
    // start held high for 12 cycles: one edge only; tick every 4 cycles
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = (i % 4 == 0) ? 7'b0111000 : 7'b0110000;
      if (bus.cnt_inc === 1'b1) pulses++;
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL run_tick[%0d]: got %b want %b", i, obs, exp); end
    end
    n_cmp++;
    if (pulses !== 3) begin n_bad++; $display("FAIL run_pulse_count: got %0d want 3", pulses); end
    bus.btn_start = 1'b0;
  endtask

  task automatic test_pause_resume();
    step(); step();                  // prescaler 0->1->2
    bus.btn_stop = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b1000000) begin n_bad++; $display("FAIL pause_entry: got %b want %b", obs, 7'b1000000); end
    bus.btn_stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (obs !== 7'b1000000) begin n_bad++; $display("FAIL pause_hold[%0d]: got %b want %b", i, obs, 7'b1000000); end
    end
    bus.btn_start = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b0110000) begin n_bad++; $display("FAIL resume_entry: got %b want %b", obs, 7'b0110000); end
    bus.btn_start = 1'b0;
    step();
    n_cmp++;
    if (obs !== 7'b0110000) begin n_bad++; $display("FAIL resume_plus1: got %b want %b", obs, 7'b0110000); end
    step();
    n_cmp++;
    if (obs !== 7'b0111000) begin n_bad++; $display("FAIL resume_plus2_inc: got %b want %b", obs, 7'b0111000); end
  endtask

  task automatic test_stop_on_tick();
    step(); step(); step();          // prescaler 0->1->2->3
    bus.btn_stop = 1'b1;
    step();                          // stop coincides with tick
    n_cmp++;
    if (obs !== 7'b1000000) begin n_bad++; $display("FAIL stop_on_tick: got %b want %b", obs, 7'b1000000); end
    bus.btn_stop = 1'b0;
    step();
    bus.btn_start = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b0110000) begin n_bad++; $display("FAIL tick_resume_entry: got %b want %b", obs, 7'b0110000); end
    bus.btn_start = 1'b0;
    step();
    n_cmp++;
    if (obs !== 7'b0111000) begin n_bad++; $display("FAIL tick_resume_inc: got %b want %b", obs, 7'b0111000); end
  endtask

  task automatic test_pause_load();
    logic [6:0] exp;
    step(); step();                  // prescaler 0->1->2
    bus.btn_stop = 1'b1;
    step();
    bus.btn_stop = 1'b0;
    bus.btn_load = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b1000100) begin n_bad++; $display("FAIL pause_load: got %b want %b", obs, 7'b1000100); end
    bus.btn_load = 1'b0;
    step();
    n_cmp++;
    if (obs !== 7'b1000000) begin n_bad++; $display("FAIL pause_load_end: got %b want %b", obs, 7'b1000000); end
    bus.btn_start = 1'b1;
    step();
    bus.btn_start = 1'b0;
    // prescaler was zeroed by load: a full 4 cycles to the next tick
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4) ? 7'b0111000 : 7'b0110000;
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL load_resume[%0d]: got %b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_priority();
    bus.btn_clear = 1'b1; bus.btn_stop = 1'b1; bus.btn_load = 1'b1; bus.btn_start = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b0000010) begin n_bad++; $display("FAIL priority_clear: got %b want %b", obs, 7'b0000010); end
    step();
    n_cmp++;
    if (obs !== 7'b0000000) begin n_bad++; $display("FAIL priority_after: got %b want %b", obs, 7'b0000000); end
    bus.btn_clear = 1'b0; bus.btn_stop = 1'b0; bus.btn_load = 1'b0; bus.btn_start = 1'b0;
    step();
  endtask

  task automatic test_done_load();
    bus.btn_load = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b0000100) begin n_bad++; $display("FAIL idle_load: got %b want %b", obs, 7'b0000100); end
    bus.btn_load = 1'b0;
    bus.btn_start = 1'b1;
    step();
    bus.btn_start = 1'b0;
    bus.cnt_term = 1'b1;
    step(); step(); step();
    n_cmp++;
    if (obs !== 7'b0110000) begin n_bad++; $display("FAIL term_pre_tick: got %b want %b", obs, 7'b0110000); end
    step();
    n_cmp++;
    if (obs !== 7'b1100001) begin n_bad++; $display("FAIL term_done: got %b want %b", obs, 7'b1100001); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (obs !== 7'b1100001) begin n_bad++; $display("FAIL done_hold[%0d]: got %b want %b", i, obs, 7'b1100001); end
    end
    bus.btn_start = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b1100001) begin n_bad++; $display("FAIL done_start_ignored: got %b want %b", obs, 7'b1100001); end
    bus.btn_start = 1'b0;
    bus.btn_stop = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b1100001) begin n_bad++; $display("FAIL done_stop_ignored: got %b want %b", obs, 7'b1100001); end
    bus.btn_stop = 1'b0;
    bus.btn_load = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b0000100) begin n_bad++; $display("FAIL done_load: got %b want %b", obs, 7'b0000100); end
    bus.btn_load = 1'b0;
    bus.cnt_term = 1'b0;
    step();
    n_cmp++;
    if (obs !== 7'b0000000) begin n_bad++; $display("FAIL done_load_end: got %b want %b", obs, 7'b0000000); end
  endtask

  task automatic test_async_reset();
    bus.btn_start = 1'b1;
    step();
    bus.btn_start = 1'b0;
    step(); step(); step();
    step();
    n_cmp++;
    if (obs !== 7'b0111000) begin n_bad++; $display("FAIL areset_pre_inc: got %b want %b", obs, 7'b0111000); end
    #2;
    reset = 1'b0;
    #1;                              // still before the next rising edge
    n_cmp++;
    if (obs !== 7'b0000000) begin n_bad++; $display("FAIL areset_immediate: got %b want %b", obs, 7'b0000000); end
    step();
    bus.btn_start = 1'b1;            // held across reset release
    reset = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b0110000) begin n_bad++; $display("FAIL areset_held_start: got %b want %b", obs, 7'b0110000); end
    step();
    n_cmp++;
    if (obs !== 7'b0110000) begin n_bad++; $display("FAIL areset_single_edge: got %b want %b", obs, 7'b0110000); end
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b1;
    step();
    n_cmp++;
    if (obs !== 7'b0000010) begin n_bad++; $display("FAIL final_clear: got %b want %b", obs, 7'b0000010); end
    bus.btn_clear = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_run_ticks();
    test_pause_resume();
    test_stop_on_tick();
    test_pause_load();
    test_priority();
    test_done_load();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
